// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU issue/collect front end.
// Function code constants stay with the ALU itself.
package alu_pkg;

    localparam int unsigned ALU_WIDTH  = 32;
    localparam int unsigned ALU_FLAG_W = 4;
    localparam int unsigned ALU_TAG_W  = 4;

    // Response record at the default widths; alu_sequencer packs the same field order.
    typedef struct packed {
        logic [ALU_WIDTH-1:0]  result;
        logic [ALU_FLAG_W-1:0] flags;
        logic [ALU_TAG_W-1:0]  tag;
    } alu_rsp_t;

    // Counter width able to hold 0..depth inclusive.
    function automatic int unsigned credit_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// First-word-fall-through response FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module alu_rsp_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 40,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [DATA_W-1:0]         push_data,
    input  logic                      pop,
    output logic [DATA_W-1:0]         head_data,
    output logic                      head_valid,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = credit_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && (count_q != '0);
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read until count marks it valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data  = mem_q[rd_ptr_q];
    assign head_valid = (count_q != '0);
    assign count      = count_q;

endmodule

// File: rtl/alu_sequencer.sv
// Issue/collect front end for the ALU: registers operands on accept, tracks ops
// through the fixed ALU latency and returns tagged results in order via a credited FIFO.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned FUNC_W    = 6,
    parameter int unsigned FLAG_W    = 4,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned ALU_LAT   = 1,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [WIDTH-1:0]  req_a,
    input  logic [WIDTH-1:0]  req_b,
    input  logic [FUNC_W-1:0] req_func,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [WIDTH-1:0]  alu_operand_a,
    output logic [WIDTH-1:0]  alu_operand_b,
    output logic [FUNC_W-1:0] alu_func,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_result,
    output logic [FLAG_W-1:0] rsp_flags,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              busy
);

    localparam int unsigned STAGES = ALU_LAT + 1;
    localparam int unsigned CNT_W  = credit_w(RSP_DEPTH);
    localparam int unsigned RSP_W  = WIDTH + FLAG_W + TAG_W;
    localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(RSP_DEPTH);

    logic              accept;
    logic              capture;
    logic              rsp_pop;
    logic [STAGES-1:0] trk_valid_q;
    logic [TAG_W-1:0]  trk_tag_q [STAGES];
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [CNT_W:0]    credits_used;
    logic [RSP_W-1:0]  push_data;
    logic [RSP_W-1:0]  head_data;

    assign accept  = req_valid && req_ready;
    assign capture = trk_valid_q[STAGES-1];
    assign rsp_pop = rsp_valid && rsp_ready;

    // Operand registers hold when idle so the ALU inputs stay quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_operand_a <= '0;
            alu_operand_b <= '0;
            alu_func      <= '0;
        end else if (accept) begin
            alu_operand_a <= req_a;
            alu_operand_b <= req_b;
            alu_func      <= req_func;
        end
    end

    // In-flight tracker: the last stage lines up with the ALU result being stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                trk_tag_q[i] <= '0;
            end
        end else begin
            trk_valid_q  <= {trk_valid_q[STAGES-2:0], accept};
            trk_tag_q[0] <= req_tag;
            for (int i = 1; i < STAGES; i++) begin
                trk_tag_q[i] <= trk_tag_q[i-1];
            end
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        if (accept && !capture) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!accept && capture) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    // Every in-flight op owns a FIFO slot, so captures can never be refused.
    assign credits_used = {1'b0, inflight_q} + {1'b0, fifo_cnt};
    assign req_ready    = rst_n && (credits_used < DEPTH_LIM);
    assign busy         = (inflight_q != '0) || (fifo_cnt != '0);

    assign push_data = {alu_result, alu_flags, trk_tag_q[STAGES-1]};

    alu_rsp_fifo #(
        .DATA_W (RSP_W),
        .DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (capture),
        .push_data  (push_data),
        .pop        (rsp_pop),
        .head_data  (head_data),
        .head_valid (rsp_valid),
        .count      (fifo_cnt)
    );

    assign {rsp_result, rsp_flags, rsp_tag} = head_data;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer driving a behavioural single-cycle ALU.
module tb_alu_sequencer;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned FUNC_W    = 6;
    localparam int unsigned FLAG_W    = 4;
    localparam int unsigned TAG_W     = 4;
    localparam int unsigned ALU_LAT   = 1;
    localparam int unsigned RSP_DEPTH = 4;

    localparam logic [5:0] FuncAdd = 6'd0;
    localparam logic [5:0] FuncSub = 6'd1;
    localparam logic [5:0] FuncAnd = 6'd2;
    localparam logic [5:0] FuncOr  = 6'd3;
    localparam logic [5:0] FuncXor = 6'd4;

    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  flags;
        logic [3:0]  tag;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid;
    logic              req_ready;
    logic [WIDTH-1:0]  req_a;
    logic [WIDTH-1:0]  req_b;
    logic [FUNC_W-1:0] req_func;
    logic [TAG_W-1:0]  req_tag;
    logic [WIDTH-1:0]  alu_operand_a;
    logic [WIDTH-1:0]  alu_operand_b;
    logic [FUNC_W-1:0] alu_func;
    logic [WIDTH-1:0]  alu_result;
    logic [FLAG_W-1:0] alu_flags;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_result;
    logic [FLAG_W-1:0] rsp_flags;
    logic [TAG_W-1:0]  rsp_tag;
    logic              busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_pops = 0;
    exp_t exp_q[$];
    int   pop_cyc_q[$];
    exp_t mon_e;

    logic [5:0]  funcs [5] = '{FuncAdd, FuncSub, FuncAnd, FuncOr, FuncXor};
    logic [31:0] ra, rb;
    logic [5:0]  rf;
    logic [3:0]  rt;
    int          accepted;
    int          sent;
    int          pops_before;
    logic        took;

    always #5 clk = ~clk;

    alu_sequencer #(
        .WIDTH     (WIDTH),
        .FUNC_W    (FUNC_W),
        .FLAG_W    (FLAG_W),
        .TAG_W     (TAG_W),
        .ALU_LAT   (ALU_LAT),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_func      (req_func),
        .req_tag       (req_tag),
        .alu_operand_a (alu_operand_a),
        .alu_operand_b (alu_operand_b),
        .alu_func      (alu_func),
        .alu_result    (alu_result),
        .alu_flags     (alu_flags),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_flags     (rsp_flags),
        .rsp_tag       (rsp_tag),
        .busy          (busy)
    );

    // Reference ALU arithmetic: returns {n, z, c, v, result}.
    function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [5:0] f);
        logic [32:0] wide;
        logic [31:0] r;
        logic        c;
        logic        v;
        c = 1'b0;
        v = 1'b0;
        case (f)
            FuncAdd: begin
                wide = {1'b0, a} + {1'b0, b};
                r    = wide[31:0];
                c    = wide[32];
                v    = (a[31] == b[31]) && (r[31] != a[31]);
            end
            FuncSub: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            FuncAnd: r = a & b;
            FuncOr:  r = a | b;
            FuncXor: r = a ^ b;
            default: r = '0;
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    // ALU with one cycle of latency, as the sequencer expects.
    always @(posedge clk) begin
        {alu_flags, alu_result} <= alu_ref(alu_operand_a, alu_operand_b, alu_func);
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f,
                            input logic [3:0] tag, input logic [31:0] res);
        logic [35:0] r;
        exp_t        e;
        r        = alu_ref(a, b, f);
        e.result = res;
        e.flags  = r[35:32];
        e.tag    = tag;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f,
                         input logic [3:0] tag, input logic [31:0] res);
        int n = 0;
        req_a     = a;
        req_b     = b;
        req_func  = f;
        req_tag   = tag;
        req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (req_ready) begin
            push_exp(a, b, f, tag, res);
        end else begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: req_ready got 0 expected 1");
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: a handshake seen at negedge completes at the following posedge.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got tag %0h result %0h expected no response",
                         rsp_tag, rsp_result);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_result", 64'(rsp_result), 64'(mon_e.result));
                check("rsp_flags", 64'(rsp_flags), 64'(mon_e.flags));
                check("rsp_tag", 64'(rsp_tag), 64'(mon_e.tag));
            end
            pop_cyc_q.push_back(cyc);
            n_pops++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation got stuck, expected completion");
        $fatal(1);
    end

    initial begin
        logic [35:0] r;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_func  = '0;
        req_tag   = '0;
        rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_alu_a", 64'(alu_operand_a), 64'd0);
        check("reset_alu_func", 64'(alu_func), 64'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;

        // Single op and its latency.
        rsp_ready = 1'b1;
        issue(32'd100, 32'd75, FuncAdd, 4'd3, 32'd175);
        @(negedge clk);
        check("lat_cycle0_valid", 64'(rsp_valid), 64'd0);
        check("idle_operand_a", 64'(alu_operand_a), 64'd100);
        @(negedge clk);
        check("lat_cycle1_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("lat_cycle2_valid", 64'(rsp_valid), 64'd1);
        drain(20);

        // Back-to-back subtracts return on consecutive cycles.
        pop_cyc_q.delete();
        issue(32'd7, 32'd7, FuncSub, 4'd1, 32'd0);
        issue(32'd999, 32'd1, FuncSub, 4'd2, 32'd998);
        issue(32'd9999, 32'd9999, FuncSub, 4'd4, 32'd0);
        issue(32'd99999, -32'd999, FuncSub, 4'd5, 32'd100998);
        drain(20);
        check("b2b_count", 64'(pop_cyc_q.size()), 64'd4);
        if (pop_cyc_q.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                check("b2b_gap", 64'(pop_cyc_q[i] - pop_cyc_q[i-1]), 64'd1);
            end
        end

        // Backpressure: only RSP_DEPTH ops accepted while responses are held.
        rsp_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            rt = 4'(i + 8);
            req_a     = ra;
            req_b     = rb;
            req_func  = FuncAdd;
            req_tag   = rt;
            req_valid = 1'b1;
            @(negedge clk);
            if (req_ready) begin
                r = alu_ref(ra, rb, FuncAdd);
                push_exp(ra, rb, FuncAdd, rt, r[31:0]);
                accepted++;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        check("bp_accepted", 64'(accepted), 64'd4);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_req_ready", 64'(req_ready), 64'd0);
        check("bp_busy", 64'(busy), 64'd1);
        check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_before_pop", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_ready_after_pop", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;

        // Capture and pop on the same edge with three entries queued.
        ra = $urandom;
        rb = $urandom;
        r  = alu_ref(ra, rb, FuncXor);
        issue(ra, rb, FuncXor, 4'd12, r[31:0]);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("pp_ready_at_3", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        ra = $urandom;
        rb = $urandom;
        r  = alu_ref(ra, rb, FuncOr);
        issue(ra, rb, FuncOr, 4'd13, r[31:0]);
        @(negedge clk);
        check("pp_ready_full_inflight", 64'(req_ready), 64'd0);
        repeat (3) @(negedge clk);
        check("pp_ready_full_fifo", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        drain(50);
        @(negedge clk);
        check("pp_busy_drained", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // Randomised traffic with random response backpressure.
        sent = 0;
        for (int c = 0; c < 3000 && sent < 300; c++) begin
            if (!req_valid && $urandom_range(0, 3) != 0) begin
                ra = $urandom;
                rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
                rf = funcs[$urandom_range(0, 4)];
                rt = 4'($urandom);
                req_a     = ra;
                req_b     = rb;
                req_func  = rf;
                req_tag   = rt;
                req_valid = 1'b1;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            took = req_valid && req_ready;
            if (took) begin
                r = alu_ref(ra, rb, rf);
                push_exp(ra, rb, rf, rt, r[31:0]);
                sent++;
            end
            @(posedge clk);
            #1;
            if (took) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        check("rand_sent", 64'(sent), 64'd300);
        drain(300);

        // Reset with two ops queued and two in flight.
        rsp_ready = 1'b0;
        issue(32'd1, 32'd2, FuncAdd, 4'd1, 32'd3);
        issue(32'd5, 32'd6, FuncAdd, 4'd2, 32'd11);
        repeat (3) @(posedge clk);
        #1;
        issue(32'd10, 32'd20, FuncAdd, 4'd3, 32'd30);
        issue(32'd40, 32'd50, FuncAdd, 4'd4, 32'd90);
        #2 rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_alu_a", 64'(alu_operand_a), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", 64'(req_ready), 64'd1);
        check("rst_release_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        pops_before = n_pops;
        rsp_ready   = 1'b1;
        issue(32'd300, 32'd45, FuncSub, 4'd9, 32'd255);
        drain(20);
        repeat (4) @(posedge clk);
        #1;
        check("rst_only_new_rsp", 64'(n_pops - pops_before), 64'd1);
        check("rst_idle_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
